// File: rtl/gbram_scheduler_pkg.sv
// Shared definitions for the LSTM gate BRAM schedulers: state encoding,
// default geometry and small sizing helpers.
package gbram_scheduler_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 6;
    localparam int unsigned DEF_MEM_SIZE   = 8;
    localparam int unsigned DEF_NUM_REQ    = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REARM     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_SERVE     = 3'd4
    } sched_state_e;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gbram_scheduler_rr_arbiter.sv
// Round-robin arbiter: scans requests starting at ptr and returns the first
// requester found as a one-hot grant plus its index.
module rr_arbiter
    import gbram_scheduler_pkg::*;
#(
    parameter int unsigned N     = DEF_NUM_REQ,
    parameter int unsigned PTR_W = ptr_width(DEF_NUM_REQ)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = PTR_W'((32'(ptr) + i) % N);
            if (!gnt_any && req[cand]) begin
                gnt_any   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/gbram_scheduler.sv
// Gate BRAM scheduler: streams a load sequence into the BRAM, then serves
// single-cycle reads to the gate units with round-robin arbitration.
module gbram_scheduler
    import gbram_scheduler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned MEM_SIZE   = DEF_MEM_SIZE,
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ld_start,
    input  logic                          ld_valid,
    input  logic [DATA_WIDTH-1:0]         ld_data,
    output logic                          ld_ready,
    input  logic [NUM_REQ-1:0]            rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr_in,
    output logic [NUM_REQ-1:0]            rd_gnt,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          bram_we,
    output logic                          bram_re,
    output logic [ADDR_WIDTH-1:0]         bram_wr_addr,
    output logic [ADDR_WIDTH-1:0]         bram_rd_addr,
    output logic [DATA_WIDTH-1:0]         bram_din,
    input  logic [DATA_WIDTH-1:0]         bram_dout,
    input  logic                          bram_done,
    output logic                          loaded,
    output logic                          busy
);

    localparam int unsigned     PTR_W     = ptr_width(NUM_REQ);
    localparam int unsigned     CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(MEM_SIZE - 1);
    localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);

    sched_state_e     state;
    logic [CNT_W-1:0] wr_cnt;
    logic [PTR_W-1:0] rr_ptr;
    logic             load_done_once;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_any;
    logic               in_serve;
    logic               accept;
    logic               grant;

    assign in_serve = (state == ST_SERVE);
    assign accept   = (state == ST_LOAD) && ld_valid;
    assign grant    = in_serve && arb_any;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req     (rd_req),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // Sequencer, write counter, arbitration pointer and read-return strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wr_cnt         <= '0;
            rr_ptr         <= '0;
            load_done_once <= 1'b0;
            rd_valid       <= '0;
        end else begin
            rd_valid <= rd_gnt;
            if (grant) begin
                rr_ptr <= (arb_idx == LAST_REQ) ? '0 : arb_idx + PTR_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (ld_start) begin
                        if (load_done_once) begin
                            state <= ST_REARM;
                        end else begin
                            state  <= ST_LOAD;
                            wr_cnt <= '0;
                        end
                    end
                end
                ST_REARM: begin
                    state  <= ST_LOAD;
                    wr_cnt <= '0;
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                        if (wr_cnt == LAST_WORD) begin
                            state <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (bram_done) begin
                        state          <= ST_SERVE;
                        load_done_once <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (ld_start) begin
                        state <= ST_REARM;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Same-cycle BRAM port drive; everything idles at zero outside its state.
    always_comb begin
        ld_ready     = (state == ST_LOAD);
        bram_we      = (state == ST_REARM) || accept;
        bram_wr_addr = accept ? wr_cnt[ADDR_WIDTH-1:0] : '0;
        bram_din     = accept ? ld_data : '0;
        rd_gnt       = in_serve ? arb_gnt : '0;
        bram_re      = grant;
        bram_rd_addr = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (rd_gnt[k]) begin
                bram_rd_addr = rd_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign rd_data = bram_dout;
    assign loaded  = in_serve;
    assign busy    = (state != ST_IDLE) && (state != ST_SERVE);

endmodule

// File: tb/tb_gbram_scheduler.sv
// Directed bench for gbram_scheduler with a behavioural BRAM that counts
// writes, raises done after a full load and clears on a REARM strobe.
module tb_gbram_scheduler;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;
    localparam int unsigned MS = 8;
    localparam int unsigned NR = 4;
    localparam int unsigned NV = 14;

    localparam logic [NR*AW-1:0] A0 = {6'd3, 6'd2, 6'd1, 6'd0};
    localparam logic [NR*AW-1:0] A1 = {6'd7, 6'd6, 6'd5, 6'd4};

    logic clk = 1'b0;
    logic rst_n;
    logic ld_start, ld_valid, ld_ready;
    logic [DW-1:0] ld_data;
    logic [NR-1:0] rd_req, rd_gnt, rd_valid;
    logic [NR*AW-1:0] rd_addr_in;
    logic [DW-1:0] rd_data, bram_din, bram_dout;
    logic bram_we, bram_re, bram_done, loaded, busy;
    logic [AW-1:0] bram_wr_addr, bram_rd_addr;
    logic hold_done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    gbram_scheduler #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_SIZE   (MS),
        .NUM_REQ    (NR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_start     (ld_start),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .rd_req       (rd_req),
        .rd_addr_in   (rd_addr_in),
        .rd_gnt       (rd_gnt),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .bram_we      (bram_we),
        .bram_re      (bram_re),
        .bram_wr_addr (bram_wr_addr),
        .bram_rd_addr (bram_rd_addr),
        .bram_din     (bram_din),
        .bram_dout    (bram_dout),
        .bram_done    (bram_done),
        .loaded       (loaded),
        .busy         (busy)
    );

    // Behavioural BRAM: a write strobe without ld_ready clears the load counter.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int unsigned bcnt = 0;
    int unsigned wr_events = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= 0;
        end else if (bram_we) begin
            if (ld_ready) begin
                mem[bram_wr_addr] <= bram_din;
                bcnt              <= bcnt + 1;
                wr_events         <= wr_events + 1;
            end else begin
                bcnt <= 0;
            end
        end
    end

    always @(posedge clk) begin
        if (bram_re) bram_dout <= mem[bram_rd_addr];
    end

    assign bram_done = (bcnt >= MS) && !hold_done;

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*AW-1:0] addr;
        logic [NR-1:0]    gnt;
        logic [AW-1:0]    raddr;
        logic [DW-1:0]    data;
    } vec_t;

    vec_t vec [NV];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] outs();
        return 64'({ld_ready, rd_gnt, rd_valid, bram_we, bram_re, loaded, busy,
                    bram_wr_addr, bram_rd_addr, bram_din});
    endfunction

    // Pulse ld_start from IDLE; the next cycle must already be LOAD.
    task automatic start_load();
        ld_start = 1'b1;
        #1;
        step();
        ld_start = 1'b0;
        #1;
        check("direct_load_ready", 64'(ld_ready), 64'd1);
        check("direct_load_busy", 64'(busy), 64'd1);
    endtask

    // Feed MS words from base; with toggle, ld_valid alternates 1,0,1,0...
    task automatic write_words(input logic [DW-1:0] base, input bit toggle);
        int unsigned nacc = 0;
        int unsigned cyc = 0;
        int unsigned w0;
        w0 = wr_events;
        while (nacc < MS && cyc < 40) begin
            ld_valid = !toggle || (cyc % 2 == 0);
            ld_data  = ld_valid ? base + nacc : 32'hdead_beef;
            #1;
            if (ld_valid) begin
                check("load_we", 64'(bram_we), 64'd1);
                check("load_addr", 64'(bram_wr_addr), 64'(nacc));
                check("load_din", 64'(bram_din), 64'(base + nacc));
            end else begin
                check("gap_we", 64'(bram_we), 64'd0);
            end
            step();
            if (ld_valid) nacc++;
            cyc++;
        end
        ld_valid = 1'b0;
        #1;
        check("wait_ready", 64'(ld_ready), 64'd0);
        check("wait_busy", 64'(busy), 64'd1);
        check("write_count", 64'(wr_events - w0), 64'(MS));
        ld_valid = 1'b1;
        #1;
        check("wait_ignores_valid", 64'(bram_we), 64'd0);
        ld_valid = 1'b0;
    endtask

    task automatic wait_loaded();
        for (int i = 0; i < 10 && !loaded; i++) step();
        #1;
        check("loaded", 64'(loaded), 64'd1);
        check("serve_not_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        vec[0]  = '{4'b1111, A0, 4'b0001, 6'd0, 32'h10};
        vec[1]  = '{4'b1111, A0, 4'b0010, 6'd1, 32'h11};
        vec[2]  = '{4'b1111, A0, 4'b0100, 6'd2, 32'h12};
        vec[3]  = '{4'b1111, A0, 4'b1000, 6'd3, 32'h13};
        vec[4]  = '{4'b1111, A1, 4'b0001, 6'd4, 32'h14};
        vec[5]  = '{4'b1111, A1, 4'b0010, 6'd5, 32'h15};
        vec[6]  = '{4'b1111, A1, 4'b0100, 6'd6, 32'h16};
        vec[7]  = '{4'b1111, A1, 4'b1000, 6'd7, 32'h17};
        vec[8]  = '{4'b1010, A1, 4'b0010, 6'd5, 32'h15};
        vec[9]  = '{4'b1010, A1, 4'b1000, 6'd7, 32'h17};
        vec[10] = '{4'b0000, A1, 4'b0000, 6'd0, 32'h0};
        vec[11] = '{4'b0001, A1, 4'b0001, 6'd4, 32'h14};
        vec[12] = '{4'b0001, A1, 4'b0001, 6'd4, 32'h14};
        vec[13] = '{4'b1001, A1, 4'b1000, 6'd7, 32'h17};

        rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        rd_req = '0; rd_addr_in = '0; hold_done = 1'b0;
        repeat (2) @(negedge clk);
        ld_valid = 1'b1; ld_start = 1'b1; rd_req = '1;
        #1;
        check("reset_outs", outs(), 64'd0);
        ld_valid = 1'b0; ld_start = 1'b0; rd_req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_outs", outs(), 64'd0);

        // First load, then table-driven round-robin reads.
        start_load();
        write_words(32'h10, 1'b0);
        wait_loaded();
        for (int i = 0; i < NV; i++) begin
            rd_req = vec[i].req;
            rd_addr_in = vec[i].addr;
            #1;
            check($sformatf("v%0d_gnt", i), 64'(rd_gnt), 64'(vec[i].gnt));
            check($sformatf("v%0d_re", i), 64'(bram_re), 64'(|vec[i].gnt));
            check($sformatf("v%0d_raddr", i), 64'(bram_rd_addr), 64'(vec[i].raddr));
            step();
            check($sformatf("v%0d_rvalid", i), 64'(rd_valid), 64'(vec[i].gnt));
            if (vec[i].gnt != '0)
                check($sformatf("v%0d_rdata", i), 64'(rd_data), 64'(vec[i].data));
        end

        // ld_start colliding with a grant: grant completes, then one REARM cycle.
        rd_req = 4'b0010; rd_addr_in = A1; ld_start = 1'b1;
        #1;
        check("collide_gnt", 64'(rd_gnt), 64'b0010);
        check("collide_re", 64'(bram_re), 64'd1);
        step();
        ld_start = 1'b0;
        #1;
        check("rearm_rvalid", 64'(rd_valid), 64'b0010);
        check("rearm_rdata", 64'(rd_data), 64'h15);
        check("rearm_we", 64'(bram_we), 64'd1);
        check("rearm_ready", 64'(ld_ready), 64'd0);
        check("rearm_loaded", 64'(loaded), 64'd0);
        check("rearm_busy", 64'(busy), 64'd1);
        check("rearm_no_gnt", 64'(rd_gnt), 64'd0);
        rd_req = '0;
        step();
        check("reload_ready", 64'(ld_ready), 64'd1);
        check("reload_rvalid", 64'(rd_valid), 64'd0);
        write_words(32'h20, 1'b1);
        wait_loaded();
        rd_req = 4'b0001; rd_addr_in = {6'd0, 6'd0, 6'd0, 6'd3};
        #1;
        check("reload_gnt", 64'(rd_gnt), 64'b0001);
        step();
        check("reload_rdata", 64'(rd_data), 64'h23);
        check("reload_rvalid1", 64'(rd_valid), 64'b0001);

        // Reset mid-SERVE with a grant in flight.
        rd_req = 4'b0010;
        #1;
        check("pre_rst_gnt", 64'(rd_gnt), 64'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_serve_outs", outs(), 64'd0);
        rd_req = '0;
        step();
        check("rst_rvalid_suppressed", 64'(rd_valid), 64'd0);
        rst_n = 1'b1;
        #1;

        // Reset mid-LOAD after three words; restart goes straight to LOAD.
        start_load();
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data = 32'h30 + 32'(i);
            step();
        end
        rst_n = 1'b0;
        #1;
        check("rst_load_outs", outs(), 64'd0);
        ld_valid = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        start_load();

        // Request held through WAIT_DONE is granted on the SERVE entry cycle.
        hold_done = 1'b1;
        write_words(32'h40, 1'b0);
        rd_req = 4'b0100; rd_addr_in = {6'd0, 6'd2, 6'd0, 6'd0};
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wait_no_gnt", 64'(rd_gnt), 64'd0);
            check("wait_no_re", 64'(bram_re), 64'd0);
            step();
        end
        hold_done = 1'b0;
        #1;
        check("done_edge_no_gnt", 64'(rd_gnt), 64'd0);
        step();
        check("entry_loaded", 64'(loaded), 64'd1);
        check("entry_gnt", 64'(rd_gnt), 64'b0100);
        check("entry_raddr", 64'(bram_rd_addr), 64'd2);
        step();
        check("entry_rvalid", 64'(rd_valid), 64'b0100);
        check("entry_rdata", 64'(rd_data), 64'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
